// File: rtl/rim_pkg.sv
// ---------------------------------------------------------------------------
// rim_pkg : shared constants and FSM state type for the rim path encoder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rim_pkg;
  localparam int         PATH_LEN  = 15;
  localparam int         MOVE_W    = 14;
  localparam int         COORD_W   = 3;
  localparam logic [3:0] ERR_NONE  = 4'hF;
  localparam logic [3:0] LAST_BEAT = 4'(PATH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;
endpackage

`default_nettype wire

// File: rtl/rim_step_check.sv
// ---------------------------------------------------------------------------
// rim_step_check : combinational unit-step test between two path coordinates.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rim_step_check
  import rim_pkg::*;
(
  input  logic [COORD_W-1:0] prev_row,
  input  logic [COORD_W-1:0] prev_col,
  input  logic [COORD_W-1:0] cur_row,
  input  logic [COORD_W-1:0] cur_col,
  output logic               legal,
  output logic               is_down
);

  logic [COORD_W:0] row_inc;
  logic [COORD_W:0] col_inc;
  logic             step_down;
  logic             step_right;

  // One bit of headroom so an increment from 7 can never alias back onto 0.
  assign row_inc    = {1'b0, prev_row} + (COORD_W+1)'(1);
  assign col_inc    = {1'b0, prev_col} + (COORD_W+1)'(1);
  assign step_down  = (row_inc == {1'b0, cur_row}) && (cur_col == prev_col);
  assign step_right = (col_inc == {1'b0, cur_col}) && (cur_row == prev_row);
  assign legal      = step_down || step_right;
  assign is_down    = step_down;

endmodule

`default_nettype wire

// File: rtl/rim_path_encoder.sv
// ---------------------------------------------------------------------------
// rim_path_encoder : encodes a 15-beat coordinate path into a down/right move
// vector with legality status. Optional down_cnt output via RIM_MOVE_COUNT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rim_path_encoder
  import rim_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_row,
  input  logic [COORD_W-1:0] in_col,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [MOVE_W-1:0]  moves,
  output logic               path_ok,
  output logic [3:0]         err_step,
  output logic               overrun
`ifdef RIM_MOVE_COUNT_EN
  ,
  output logic [3:0]         down_cnt
`endif
);

  state_e             state_q,    state_d;
  logic [3:0]         cnt_q,      cnt_d;
  logic [COORD_W-1:0] prev_row_q, prev_row_d;
  logic [COORD_W-1:0] prev_col_q, prev_col_d;
  logic [MOVE_W-1:0]  moves_q,    moves_d;
  logic               ok_q,       ok_d;
  logic [3:0]         err_q,      err_d;
  logic               valid_q,    valid_d;
  logic               overrun_q,  overrun_d;
`ifdef RIM_MOVE_COUNT_EN
  logic [3:0]         down_cnt_q, down_cnt_d;
`endif

  logic       step_legal;
  logic       step_down;
  logic       handshake;
  logic       start_path;
  logic       origin_ok;
  logic [3:0] step_idx;

  rim_step_check u_step_check (
    .prev_row (prev_row_q),
    .prev_col (prev_col_q),
    .cur_row  (in_row),
    .cur_col  (in_col),
    .legal    (step_legal),
    .is_down  (step_down)
  );

  assign handshake = valid_q && out_ready;
  // A beat arriving in the handshake cycle opens the next path directly.
  assign start_path = in_valid && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign origin_ok  = (in_row == '0) && (in_col == '0);
  assign step_idx   = cnt_q - 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_row_d = prev_row_q;
    prev_col_d = prev_col_q;
    moves_d    = moves_q;
    ok_d       = ok_q;
    err_d      = err_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
`ifdef RIM_MOVE_COUNT_EN
    down_cnt_d = down_cnt_q;
`endif

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          cnt_d             = cnt_q + 4'd1;
          prev_row_d        = in_row;
          prev_col_d        = in_col;
          moves_d[step_idx] = step_down;
`ifdef RIM_MOVE_COUNT_EN
          down_cnt_d        = down_cnt_q + {3'd0, step_down};
`endif
          if (ok_q && !step_legal) begin
            ok_d  = 1'b0;
            err_d = cnt_q;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          overrun_d = 1'b0;
        end else if (in_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (start_path) begin
      state_d    = COLLECT;
      cnt_d      = 4'd1;
      prev_row_d = in_row;
      prev_col_d = in_col;
      moves_d    = '0;
      ok_d       = origin_ok;
      err_d      = origin_ok ? ERR_NONE : 4'd0;
`ifdef RIM_MOVE_COUNT_EN
      down_cnt_d = 4'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      prev_row_q <= '0;
      prev_col_q <= '0;
      moves_q    <= '0;
      ok_q       <= 1'b1;
      err_q      <= ERR_NONE;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef RIM_MOVE_COUNT_EN
      down_cnt_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_row_q <= prev_row_d;
      prev_col_q <= prev_col_d;
      moves_q    <= moves_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
`ifdef RIM_MOVE_COUNT_EN
      down_cnt_q <= down_cnt_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign moves     = moves_q;
  assign path_ok   = ok_q;
  assign err_step  = err_q;
  assign overrun   = overrun_q;
`ifdef RIM_MOVE_COUNT_EN
  assign down_cnt  = down_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rim_path_encoder.sv
// ---------------------------------------------------------------------------
// tb_rim_path_encoder : self-checking bench for rim_path_encoder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rim_path_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_row;
  logic [2:0]  in_col;
  logic        out_ready;
  logic        out_valid;
  logic [13:0] moves;
  logic        path_ok;
  logic [3:0]  err_step;
  logic        overrun;
`ifdef RIM_MOVE_COUNT_EN
  logic [3:0]  down_cnt;
`endif

  rim_path_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .in_col    (in_col),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .moves     (moves),
    .path_ok   (path_ok),
    .err_step  (err_step),
`ifdef RIM_MOVE_COUNT_EN
    .down_cnt  (down_cnt),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int br[15];
  int bc[15];
  int p29r[15] = '{0,0,0,0,0,0,0,0,1,2,3,4,5,6,7};
  int p29c[15] = '{0,1,2,3,4,5,6,7,7,7,7,7,7,7,7};
  int p31r[15] = '{0,0,1,1,2,3,4,4,5,5,6,6,7,7,7};
  int p31c[15] = '{0,1,1,2,2,3,3,4,4,5,5,6,6,7,7};

  logic [13:0] e_moves;
  logic [13:0] e_mask;
  logic        e_ok;
  logic [3:0]  e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the beat list and classify each step by coordinate arithmetic.
  task automatic model();
    bit legal, dn, rt;
    e_ok = 1'b1; e_err = 4'hF; e_moves = '0; e_mask = '0;
    for (int k = 0; k < 15; k++) begin
      if (k == 0) begin
        legal = (br[0] == 0) && (bc[0] == 0);
      end else begin
        dn = (br[k] == br[k-1] + 1) && (bc[k] == bc[k-1]);
        rt = (br[k] == br[k-1]) && (bc[k] == bc[k-1] + 1);
        legal = dn || rt;
        if (e_ok && legal) begin
          e_moves[k-1] = dn;
          e_mask[k-1]  = 1'b1;
        end
      end
      if (!legal && e_ok) begin
        e_ok  = 1'b0;
        e_err = 4'(k);
      end
    end
  endtask

  task automatic gen_legal();
    int r = 0, c = 0, d = 7, rr = 7;
    br[0] = 0; bc[0] = 0;
    for (int k = 1; k < 15; k++) begin
      if (int'($urandom_range(d + rr - 1, 0)) < d) begin r++; d--; end
      else begin c++; rr--; end
      br[k] = r; bc[k] = c;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int r, input int c);
    in_valid = 1'b1; in_row = 3'(r); in_col = 3'(c);
    tick();
    in_valid = 1'b0; in_row = 3'($urandom); in_col = 3'($urandom);
  endtask

  task automatic send_beats(input int from, input int to, input bit gaps);
    for (int k = from; k <= to; k++) begin
      if (gaps) repeat ($urandom_range(2, 0)) tick();
      drive_beat(br[k], bc[k]);
    end
  endtask

  task automatic check_result(input string tag, input logic exp_ovr);
    int ones = 0;
    model();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_ok"}, path_ok, e_ok);
    chk({tag, "_err"}, err_step, e_err);
    chk({tag, "_moves"}, moves & e_mask, e_moves & e_mask);
    chk({tag, "_ovr"}, overrun, exp_ovr);
`ifdef RIM_MOVE_COUNT_EN
    for (int i = 0; i < 14; i++) ones += int'(e_moves[i]);
    if (e_ok) chk({tag, "_dcnt"}, down_cnt, ones);
`endif
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, out_valid, 1'b0);
    chk({tag, "_hs_ovr"}, overrun, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_moves"}, moves, 14'd0);
    chk({tag, "_ok"}, path_ok, 1'b1);
    chk({tag, "_err"}, err_step, 4'hF);
    chk({tag, "_ovr"}, overrun, 1'b0);
`ifdef RIM_MOVE_COUNT_EN
    chk({tag, "_dcnt"}, down_cnt, 4'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0; in_col = '0;
    repeat (3) tick();
    chk_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_reset("rst_rel");

    // Seven rights then seven downs, ready held high.
    br = p29r; bc = p29c;
    out_ready = 1'b1;
    send_beats(0, 13, 1'b0);
    chk("r29_pre_valid", out_valid, 1'b0);
    send_beats(14, 14, 1'b0);
    check_result("r29", 1'b0);
    chk("r29_literal", moves, 14'b11111110000000);
    tick();
    chk("r29_drop", out_valid, 1'b0);
    out_ready = 1'b0;

    // Bad origin.
    gen_legal(); br[0] = 0; bc[0] = 1;
    send_beats(0, 14, 1'b1);
    check_result("r30", 1'b0);
    chk("r30_err0", err_step, 4'd0);
    handshake("r30");

    // Diagonal jump at beat 5, then reset while the result is held.
    br = p31r; bc = p31c;
    send_beats(0, 14, 1'b1);
    check_result("r31", 1'b0);
    chk("r31_err5", err_step, 4'd5);
    rst_n = 1'b0;
    #1;
    chk_reset("r31_rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Held result with a dropped beat during HOLD.
    gen_legal();
    send_beats(0, 14, 1'b0);
    check_result("r32", 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) drive_beat(0, 0);
      else tick();
      check_result("r32_hold", (i >= 4) ? 1'b1 : 1'b0);
    end
    handshake("r32");
    gen_legal();
    send_beats(0, 14, 1'b1);
    check_result("r32_next", 1'b0);

    // Back-to-back: beat 0 of the next path lands in the handshake cycle.
    out_ready = 1'b1;
    br[0] = 0; bc[0] = 0;
    begin
      in_valid = 1'b1; in_row = 3'd0; in_col = 3'd0;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
    end
    chk("r33_hs_valid", out_valid, 1'b0);
    chk("r33_hs_ovr", overrun, 1'b0);
    gen_legal();
    send_beats(1, 14, 1'b1);
    check_result("r33", 1'b0);
    handshake("r33");

    // Reset after beat 7 of a downs-first path.
    for (int k = 0; k < 15; k++) begin
      br[k] = (k < 8) ? k : 7;
      bc[k] = (k < 8) ? 0 : k - 7;
    end
    send_beats(0, 7, 1'b0);
    chk("r34_partial", moves[6:0], 7'h7F);
    rst_n = 1'b0;
    #1;
    chk_reset("r34_rst");
    tick();
    rst_n = 1'b1;
    tick();
    gen_legal();
    send_beats(0, 14, 1'b1);
    check_result("r34_fresh", 1'b0);
    handshake("r34");

    // Randomized paths, some corrupted at a random beat.
    for (int n = 0; n < 10; n++) begin
      gen_legal();
      if ($urandom_range(1, 0) == 1) begin
        int k = int'($urandom_range(14, 0));
        br[k] = int'($urandom_range(7, 0));
        bc[k] = int'($urandom_range(7, 0));
      end
      send_beats(0, 14, 1'b1);
      check_result("rnd", 1'b0);
      repeat ($urandom_range(3, 0)) tick();
      handshake("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
